cache_ctl: RTL and testbench
============================

CACHE_CTL -- requirements
Module: cache_ctl

Interface
REQ-001 SHALL declare ports in this order; bit vectors are MSB-first, ascending ([0:N-1]).
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 rst  input  1  synchronous, active-high reset; one clock, sampled on the rising edge of clk.
REQ-004 enable  input  1  operation strobe; no access when low.
REQ-005 index  input  4  line select, 16 lines.
REQ-006 word  input  2  word offset within line, 4 words.
REQ-007 cmp  input  1  1 = compare (tag-checked) access, 0 = direct access.
REQ-008 write  input  1  1 = write, 0 = read.
REQ-009 tag  input  5  tag for compare or for storing.
REQ-010 data_in  input  16  write data.
REQ-011 valid_in  input  1  valid bit stored on direct write.
REQ-012 hit  output  1  compare access matched a valid line.
REQ-013 dirty  output  1  dirty bit of selected line.
REQ-014 tag_out  output  5  stored tag of selected line.
REQ-015 data_out  output  16  stored word [index][word].
REQ-016 valid  output  1  valid bit of selected line.

Function
REQ-017 Direct-mapped storage: 16 lines, each holding 5-bit tag, valid bit, dirty bit and 4 x 16-bit words.
REQ-018 All outputs are combinational from the current inputs and stored state; with enable=0, all outputs are 0.
REQ-019 Read paths with enable=1: tag_out, valid and dirty come from line[index]; data_out comes from word[index][word].
REQ-020 hit = enable & cmp & valid[index] & (tag_out == tag); hit=0 whenever cmp=0.
REQ-021 State changes only on the rising edge of clk, with enable=1 and rst=0.
REQ-022 Direct write (cmp=0, write=1): store data_in into word[index][word], tag into tag[index], valid_in into valid[index]; clear dirty[index].
REQ-023 Direct read (cmp=0, write=0): no state change.
REQ-024 Compare read (cmp=1, write=0): no state change.
REQ-025 Compare write (cmp=1, write=1) on hit: store data_in into word[index][word] and set dirty[index]=1; tag and valid are unchanged.
REQ-026 Compare write on miss: no state change; hit=0.
REQ-027 A write updates only the addressed word; the other 3 words in the line are unchanged.
REQ-028 Outputs reflect the newly written values from the cycle after the write edge.

Reset
REQ-029 On a clock edge with rst=1, clear valid, dirty, tag and data of all 16 lines to 0.
REQ-030 rst has priority over any enable operation in the same cycle; reset is independent of enable.
REQ-031 After reset, an enabled read of any line returns valid=0, dirty=0, tag_out=0, data_out=0 and hit=0.

Structure
REQ-032 A shared package SHALL hold the constants INDEX_W=4, WORD_W=2, TAG_W=5, DATA_W=16, LINES=16 and WORDS=4.
REQ-033 Implement one sub-module, cache_line_array, holding the tag, valid, dirty and data arrays with their write ports.
REQ-034 cache_ctl holds the operation decode, the hit compare and the output gating.

Verification
REQ-035 Direct write: index=0, word=3, tag=0x1D, data_in=0x0F0F, valid_in=1 -> next-cycle compare read with same tag gives hit=1, data_out=0x0F0F, valid=1, dirty=0.
REQ-036 Same line, compare read with tag=0x1C -> hit=0, tag_out=0x1D, valid=1.
REQ-037 Compare write on hit: index=0, word=1, data_in=0xABCD, tag=0x1D -> next-cycle read gives data_out=0xABCD, dirty=1; word 3 still reads 0x0F0F.
REQ-038 Compare write on miss with tag=0x02 -> line unchanged, dirty unchanged, hit=0.
REQ-039 rst=1 with enable=1 for one edge, then direct read of index 0 -> valid=0, dirty=0, tag_out=0, data_out=0.
REQ-040 enable=0 with any other inputs -> all outputs 0 and no state change across multiple edges.

Source files
------------

// File: rtl/cache_ctl_pkg.sv
// Shared geometry constants for the direct-mapped cache controller.
package cache_ctl_pkg;
  localparam int unsigned INDEX_W = 4;
  localparam int unsigned WORD_W  = 2;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned LINES   = 16;
  localparam int unsigned WORDS   = 4;
endpackage

// File: rtl/cache_line_array.sv
// Line storage: tag, valid, dirty and data arrays with a single write port
// and an asynchronous read of the addressed line/word.
module cache_line_array
  import cache_ctl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INDEX_W-1:0]   index_i,
  input  logic [WORD_W-1:0]    word_i,
  input  logic                 line_we_i,
  input  logic                 word_we_i,
  input  logic                 dirty_set_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 valid_i,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [DATA_W-1:0]    data_o
);

  logic [TAG_W-1:0]  tag_q   [LINES];
  logic [DATA_W-1:0] data_q  [LINES][WORDS];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  // Metadata: a direct write replaces tag/valid and cleans the line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int unsigned i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
      end
    end else if (line_we_i) begin
      tag_q[index_i]   <= tag_i;
      valid_q[index_i] <= valid_i;
      dirty_q[index_i] <= 1'b0;
    end else if (dirty_set_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Data: only the addressed word of the line is touched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        for (int unsigned j = 0; j < WORDS; j++) begin
          data_q[i][j] <= '0;
        end
      end
    end else if (word_we_i) begin
      data_q[index_i][word_i] <= data_i;
    end
  end

  always_comb begin
    tag_o   = tag_q[index_i];
    valid_o = valid_q[index_i];
    dirty_o = dirty_q[index_i];
    data_o  = data_q[index_i][word_i];
  end

endmodule

// File: rtl/cache_ctl.sv
// Direct-mapped cache controller: operation decode, tag compare and output
// gating around the line array. Outputs are combinational by design.
module cache_ctl
  import cache_ctl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [0:INDEX_W-1]   index,
  input  logic [0:WORD_W-1]    word,
  input  logic                 cmp,
  input  logic                 write,
  input  logic [0:TAG_W-1]     tag,
  input  logic [0:DATA_W-1]    data_in,
  input  logic                 valid_in,
  output logic                 hit,
  output logic                 dirty,
  output logic [0:TAG_W-1]     tag_out,
  output logic [0:DATA_W-1]    data_out,
  output logic                 valid
);

  logic [INDEX_W-1:0] index_c;
  logic [WORD_W-1:0]  word_c;
  logic [TAG_W-1:0]   tag_c;
  logic [DATA_W-1:0]  data_in_c;
  logic [TAG_W-1:0]   line_tag;
  logic [DATA_W-1:0]  line_data;
  logic               line_valid;
  logic               line_dirty;
  logic               hit_c;
  logic               direct_wr_c;
  logic               cmp_wr_c;

  assign index_c   = index;
  assign word_c    = word;
  assign tag_c     = tag;
  assign data_in_c = data_in;

  // Decode: direct writes always land, compare writes only on a hit.
  always_comb begin
    hit_c       = enable & cmp & line_valid & (line_tag == tag_c);
    direct_wr_c = enable & ~cmp & write;
    cmp_wr_c    = hit_c & write;
  end

  cache_line_array u_array (
    .clk_i       (clk),
    .rst_i       (rst),
    .index_i     (index_c),
    .word_i      (word_c),
    .line_we_i   (direct_wr_c),
    .word_we_i   (direct_wr_c | cmp_wr_c),
    .dirty_set_i (cmp_wr_c),
    .tag_i       (tag_c),
    .data_i      (data_in_c),
    .valid_i     (valid_in),
    .tag_o       (line_tag),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .data_o      (line_data)
  );

  always_comb begin
    hit      = 1'b0;
    dirty    = 1'b0;
    valid    = 1'b0;
    tag_out  = '0;
    data_out = '0;
    if (enable) begin
      hit      = hit_c;
      dirty    = line_dirty;
      valid    = line_valid;
      tag_out  = line_tag;
      data_out = line_data;
    end
  end

endmodule

// File: tb/tb_cache_ctl.sv
// Self-checking bench for cache_ctl against an array-based behavioural model.
module tb_cache_ctl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  index;
  logic [1:0]  word;
  logic        cmp;
  logic        write;
  logic [4:0]  tag;
  logic [15:0] data_in;
  logic        valid_in;
  logic        hit;
  logic        dirty;
  logic [4:0]  tag_out;
  logic [15:0] data_out;
  logic        valid;

  int errors = 0;
  int checks = 0;

  logic [4:0]  m_tag   [16];
  logic        m_valid [16];
  logic        m_dirty [16];
  logic [15:0] m_data  [16][4];

  cache_ctl dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .index    (index),
    .word     (word),
    .cmp      (cmp),
    .write    (write),
    .tag      (tag),
    .data_in  (data_in),
    .valid_in (valid_in),
    .hit      (hit),
    .dirty    (dirty),
    .tag_out  (tag_out),
    .data_out (data_out),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {hit, dirty, tag_out, data_out, valid} for the current inputs.
  function automatic logic [23:0] model_out();
    logic h;
    if (!enable) return 24'h0;
    h = cmp && m_valid[index] && (m_tag[index] == tag);
    return {h, m_dirty[index], m_tag[index], m_data[index][word], m_valid[index]};
  endfunction

  function automatic logic [23:0] dut_out();
    return {hit, dirty, tag_out, data_out, valid};
  endfunction

  task automatic model_update();
    logic h;
    h = cmp && m_valid[index] && (m_tag[index] == tag);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_tag[i] = 5'h0; m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        for (int j = 0; j < 4; j++) m_data[i][j] = 16'h0;
      end
    end else if (enable && write) begin
      if (!cmp) begin
        m_data[index][word] = data_in;
        m_tag[index]   = tag;
        m_valid[index] = valid_in;
        m_dirty[index] = 1'b0;
      end else if (h) begin
        m_data[index][word] = data_in;
        m_dirty[index] = 1'b1;
      end
    end
  endtask

  task automatic set_in(input logic r, input logic en, input logic [3:0] idx,
                        input logic [1:0] wd, input logic c, input logic w,
                        input logic [4:0] tg, input logic [15:0] d, input logic v);
    @(negedge clk);
    rst = r; enable = en; index = idx; word = wd; cmp = c; write = w;
    tag = tg; data_in = d; valid_in = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic test_reset();
    logic [23:0] got;
    set_in(1'b1, 1'b1, 4'h0, 2'h0, 1'b0, 1'b1, 5'h0, 16'h0, 1'b1);
    tick();
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 1'b1, 4'(i), 2'(i), i[0], 1'b0, 5'h0, 16'h0, 1'b0);
      got = dut_out();
      checks++;
      if (got !== 24'h0) begin
        errors++;
        $display("FAIL reset_line%0d: got %h expected %h", i, got, 24'h0);
      end
    end
  endtask

  task automatic test_directed();
    logic [23:0] got;
    set_in(1'b0, 1'b1, 4'h0, 2'h3, 1'b0, 1'b1, 5'h1D, 16'h0F0F, 1'b1);
    tick();
    set_in(1'b0, 1'b1, 4'h0, 2'h3, 1'b1, 1'b0, 5'h1D, 16'h0, 1'b0);
    got = dut_out(); checks++;
    if (got !== {1'b1, 1'b0, 5'h1D, 16'h0F0F, 1'b1}) begin
      errors++; $display("FAIL direct_wr_hit: got %h expected %h", got, {1'b1, 1'b0, 5'h1D, 16'h0F0F, 1'b1});
    end
    set_in(1'b0, 1'b1, 4'h0, 2'h3, 1'b1, 1'b0, 5'h1C, 16'h0, 1'b0);
    got = dut_out(); checks++;
    if (got !== {1'b0, 1'b0, 5'h1D, 16'h0F0F, 1'b1}) begin
      errors++; $display("FAIL cmp_rd_miss: got %h expected %h", got, {1'b0, 1'b0, 5'h1D, 16'h0F0F, 1'b1});
    end
    set_in(1'b0, 1'b1, 4'h0, 2'h1, 1'b1, 1'b1, 5'h1D, 16'hABCD, 1'b0);
    got = dut_out(); checks++;
    if (got !== {1'b1, 1'b0, 5'h1D, 16'h0000, 1'b1}) begin
      errors++; $display("FAIL cmp_wr_hit_pre: got %h expected %h", got, {1'b1, 1'b0, 5'h1D, 16'h0000, 1'b1});
    end
    tick();
    set_in(1'b0, 1'b1, 4'h0, 2'h1, 1'b0, 1'b0, 5'h00, 16'h0, 1'b0);
    got = dut_out(); checks++;
    if (got !== {1'b0, 1'b1, 5'h1D, 16'hABCD, 1'b1}) begin
      errors++; $display("FAIL cmp_wr_hit_word1: got %h expected %h", got, {1'b0, 1'b1, 5'h1D, 16'hABCD, 1'b1});
    end
    set_in(1'b0, 1'b1, 4'h0, 2'h3, 1'b0, 1'b0, 5'h00, 16'h0, 1'b0);
    got = dut_out(); checks++;
    if (got !== {1'b0, 1'b1, 5'h1D, 16'h0F0F, 1'b1}) begin
      errors++; $display("FAIL cmp_wr_hit_word3: got %h expected %h", got, {1'b0, 1'b1, 5'h1D, 16'h0F0F, 1'b1});
    end
    set_in(1'b0, 1'b1, 4'h0, 2'h1, 1'b1, 1'b1, 5'h02, 16'h5555, 1'b0);
    got = dut_out(); checks++;
    if (got !== {1'b0, 1'b1, 5'h1D, 16'hABCD, 1'b1}) begin
      errors++; $display("FAIL cmp_wr_miss_pre: got %h expected %h", got, {1'b0, 1'b1, 5'h1D, 16'hABCD, 1'b1});
    end
    tick();
    set_in(1'b0, 1'b1, 4'h0, 2'h1, 1'b0, 1'b0, 5'h00, 16'h0, 1'b0);
    got = dut_out(); checks++;
    if (got !== {1'b0, 1'b1, 5'h1D, 16'hABCD, 1'b1}) begin
      errors++; $display("FAIL cmp_wr_miss_post: got %h expected %h", got, {1'b0, 1'b1, 5'h1D, 16'hABCD, 1'b1});
    end
  endtask

  task automatic test_reset_priority();
    logic [23:0] got;
    set_in(1'b1, 1'b1, 4'h0, 2'h3, 1'b0, 1'b1, 5'h1F, 16'hFFFF, 1'b1);
    tick();
    set_in(1'b0, 1'b1, 4'h0, 2'h3, 1'b0, 1'b0, 5'h00, 16'h0, 1'b0);
    got = dut_out(); checks++;
    if (got !== 24'h0) begin
      errors++; $display("FAIL rst_priority_read: got %h expected %h", got, 24'h0);
    end
    set_in(1'b0, 1'b1, 4'h0, 2'h1, 1'b1, 1'b0, 5'h00, 16'h0, 1'b0);
    got = dut_out(); checks++;
    if (got !== 24'h0) begin
      errors++; $display("FAIL rst_priority_cmp: got %h expected %h", got, 24'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] got, exp;
    logic [3:0] idx;
    logic [1:0] wd;
    for (int i = 0; i < 12; i++) begin
      idx = 4'($urandom_range(0, 15));
      wd  = 2'($urandom_range(0, 3));
      set_in(1'b0, 1'b1, idx, wd, 1'b0, 1'b1, 5'($urandom), 16'($urandom), 1'b1);
      tick();
      set_in(1'b0, 1'b1, idx, wd, 1'b1, 1'b1, m_tag[idx], 16'($urandom), 1'b0);
      got = dut_out(); exp = model_out(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b_hit%0d: got %h expected %h", i, got, exp);
      end
      tick();
      set_in(1'b0, 1'b1, idx, wd, 1'b0, 1'b0, 5'h0, 16'h0, 1'b0);
      got = dut_out(); exp = model_out(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b_read%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_disable();
    logic [23:0] got, exp;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b0, 4'($urandom), 2'($urandom), 1'($urandom), 1'b1,
             5'($urandom), 16'($urandom), 1'($urandom));
      got = dut_out(); checks++;
      if (got !== 24'h0) begin
        errors++; $display("FAIL disabled_out%0d: got %h expected %h", i, got, 24'h0);
      end
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 1'b1, 4'(i), 2'($urandom), 1'b1, 1'b0, m_tag[i], 16'h0, 1'b0);
      got = dut_out(); exp = model_out(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL disabled_state%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
             4'($urandom_range(0, 7)), 2'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 3) != 0));
      got = dut_out(); exp = model_out(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random%0d: got %h expected %h", i, got, exp);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; index = '0; word = '0; cmp = 1'b0; write = 1'b0;
    tag = '0; data_in = '0; valid_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_tag[i] = 5'h0; m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
      for (int j = 0; j < 4; j++) m_data[i][j] = 16'h0;
    end
    test_reset();
    test_directed();
    test_reset_priority();
    test_back_to_back();
    test_disable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
